// File: rtl/exe_stage.sv
// MIPS execute stage: operand forwarding, ALU, HI/LO registers with a
// multi-cycle multiply/divide unit, and the E/M pipeline register.
module exe_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IRE,
    input  logic [31:0] PC4E,
    input  logic [31:0] RSE,
    input  logic [31:0] RTE,
    input  logic [31:0] EXTE,
    input  logic [1:0]  Forward_RS_E_Sel,
    input  logic [1:0]  Forward_RT_E_Sel,
    input  logic [31:0] WD_W,
    output logic [31:0] IRM,
    output logic [31:0] PC4M,
    output logic [31:0] AOM,
    output logic [31:0] RTM,
    output logic        Start,
    output logic        Busy
);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00, OPC_JAL = 6'h03, OPC_ORI = 6'h0D,
                           OPC_LUI   = 6'h0F, OPC_LW  = 6'h23, OPC_SW  = 6'h2B;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12,
                           FN_MTLO = 6'h13, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                           FN_SLT  = 6'h2A;

    // Power-up values match the reset state.
    logic [31:0] irm_q = '0, pc4m_q = '0, aom_q = '0, rtm_q = '0;
    logic [31:0] hi_q = '0, lo_q = '0, opa_q = '0, opb_q = '0;
    logic [3:0]  cnt_q = '0;
    logic        busy_q = 1'b0;
    md_op_e      op_q = OP_MULT;

    logic [31:0] hi_d, lo_d, opa_d, opb_d;
    logic [3:0]  cnt_d;
    logic        busy_d;
    md_op_e      op_d;

    logic [5:0]  opcode, funct;
    logic        is_r, is_md, is_mthi, is_mtlo;
    logic [31:0] fwd_rs, fwd_rt, op_b, result;
    logic [63:0] md_res;
    logic        div_zero;

    assign opcode  = IRE[31:26];
    assign funct   = IRE[5:0];
    assign is_r    = (opcode == OPC_RTYPE);
    assign is_md   = is_r && (funct[5:2] == 4'b0110);
    assign is_mthi = is_r && (funct == FN_MTHI);
    assign is_mtlo = is_r && (funct == FN_MTLO);
    assign Start   = is_md && !busy_q;
    assign Busy    = busy_q;

    always_comb begin
        case (Forward_RS_E_Sel)
            2'd1:    fwd_rs = aom_q;
            2'd2:    fwd_rs = pc4m_q + 32'd4;
            2'd3:    fwd_rs = WD_W;
            default: fwd_rs = RSE;
        endcase
        case (Forward_RT_E_Sel)
            2'd1:    fwd_rt = aom_q;
            2'd2:    fwd_rt = pc4m_q + 32'd4;
            2'd3:    fwd_rt = WD_W;
            default: fwd_rt = RTE;
        endcase
    end

    assign op_b = is_r ? fwd_rt : EXTE;

    always_comb begin
        result = '0;
        if (is_r) begin
            case (funct)
                FN_ADDU: result = fwd_rs + op_b;
                FN_SUBU: result = fwd_rs - op_b;
                FN_SLT:  result = {31'd0, $signed(fwd_rs) < $signed(op_b)};
                FN_MFHI: result = hi_q;
                FN_MFLO: result = lo_q;
                default: result = '0;
            endcase
        end else begin
            case (opcode)
                OPC_ORI:        result = fwd_rs | op_b;
                OPC_LUI:        result = op_b;
                OPC_LW, OPC_SW: result = fwd_rs + op_b;
                OPC_JAL:        result = PC4E + 32'd4;
                default:        result = '0;
            endcase
        end
    end

    // Result is formed from the operands latched at Start; {HI, LO} order.
    always_comb begin
        md_res = '0;
        case (op_q)
            OP_MULT:  md_res = $signed({{32{opa_q[31]}}, opa_q}) *
                               $signed({{32{opb_q[31]}}, opb_q});
            OP_MULTU: md_res = {32'd0, opa_q} * {32'd0, opb_q};
            OP_DIV:   if (opb_q != '0)
                          md_res = {$signed(opa_q) % $signed(opb_q),
                                    $signed(opa_q) / $signed(opb_q)};
            OP_DIVU:  if (opb_q != '0)
                          md_res = {opa_q % opb_q, opa_q / opb_q};
            default:  md_res = '0;
        endcase
    end

    assign div_zero = (op_q == OP_DIV || op_q == OP_DIVU) && (opb_q == '0);

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                if (!div_zero) {hi_d, lo_d} = md_res;
            end
        end else if (Start) begin
            opa_d  = fwd_rs;
            opb_d  = fwd_rt;
            op_d   = md_op_e'(funct[1:0]);
            cnt_d  = funct[1] ? 4'd10 : 4'd5;
            busy_d = 1'b1;
        end else if (is_mthi) begin
            hi_d = fwd_rs;
        end else if (is_mtlo) begin
            lo_d = fwd_rs;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            irm_q  <= '0;
            pc4m_q <= '0;
            aom_q  <= '0;
            rtm_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            op_q   <= OP_MULT;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            irm_q  <= IRE;
            pc4m_q <= PC4E;
            aom_q  <= result;
            rtm_q  <= fwd_rt;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign IRM  = irm_q;
    assign PC4M = pc4m_q;
    assign AOM  = aom_q;
    assign RTM  = rtm_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU, forwarding, mult/div, reset abort.
module tb_exe_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IRE, PC4E, RSE, RTE, EXTE, WD_W;
    logic [1:0]  Forward_RS_E_Sel, Forward_RT_E_Sel;
    logic [31:0] IRM, PC4M, AOM, RTM;
    logic        Start, Busy;
    int          checks = 0;
    int          failures = 0;

    exe_stage dut (
        .Clk(Clk), .Reset(Reset), .IRE(IRE), .PC4E(PC4E), .RSE(RSE), .RTE(RTE),
        .EXTE(EXTE), .Forward_RS_E_Sel(Forward_RS_E_Sel),
        .Forward_RT_E_Sel(Forward_RT_E_Sel), .WD_W(WD_W), .IRM(IRM), .PC4M(PC4M),
        .AOM(AOM), .RTM(RTM), .Start(Start), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    localparam logic [31:0] I_ADDU  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    localparam logic [31:0] I_SUBU  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h23};
    localparam logic [31:0] I_SLT   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A};
    localparam logic [31:0] I_MFHI  = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h10};
    localparam logic [31:0] I_MTHI  = {6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 6'h11};
    localparam logic [31:0] I_MFLO  = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h12};
    localparam logic [31:0] I_MTLO  = {6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 6'h13};
    localparam logic [31:0] I_MULT  = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h18};
    localparam logic [31:0] I_MULTU = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h19};
    localparam logic [31:0] I_DIV   = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h1A};
    localparam logic [31:0] I_DIVU  = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h1B};
    localparam logic [31:0] I_ORI   = {6'h0D, 5'd1, 5'd2, 16'h000F};
    localparam logic [31:0] I_LUI   = {6'h0F, 5'd0, 5'd2, 16'h1234};
    localparam logic [31:0] I_LW    = {6'h23, 5'd1, 5'd2, 16'h0008};
    localparam logic [31:0] I_JAL   = {6'h03, 26'h0000C00};

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] ir, rs, rt, ext, pc4,
                          input logic [1:0] srs, srt);
        IRE = ir; RSE = rs; RTE = rt; EXTE = ext; PC4E = pc4;
        Forward_RS_E_Sel = srs; Forward_RT_E_Sel = srt;
    endtask

    task automatic issue(input logic [31:0] ir, rs, rt, ext, pc4,
                         input logic [1:0] srs, srt);
        set_in(ir, rs, rt, ext, pc4, srs, srt);
        tick();
    endtask

    // Counts cycles with Busy high, bounded; leaves IRE as a bubble afterwards.
    task automatic wait_busy(output int n, input logic hold_check);
        n = 0;
        while (Busy && n < 40) begin
            if (hold_check) begin
                checks++;
                if (Start !== 1'b0) begin
                    failures++;
                    $display("FAIL hold_start cycle %0d got %b exp 0", n, Start);
                end
            end
            n++;
            tick();
        end
        set_in('0, '0, '0, '0, '0, 2'd0, 2'd0);
    endtask

    task automatic test_reset();
        Reset = 1'b1; WD_W = '0;
        set_in(I_ADDU, 32'd9, 32'd9, '0, 32'h44, 2'd0, 2'd0);
        tick(); tick();
        set_in('0, '0, '0, '0, '0, 2'd0, 2'd0);
        #1;
        checks++;
        if ({IRM, PC4M, AOM, RTM} !== '0) begin
            failures++;
            $display("FAIL reset_pipe got %h %h %h %h exp 0", IRM, PC4M, AOM, RTM);
        end
        checks++;
        if (Busy !== 1'b0 || Start !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got busy=%b start=%b exp 0 0", Busy, Start);
        end
        Reset = 1'b0;
    endtask

    task automatic test_alu();
        issue(I_ADDU, 32'd5, 32'd7, '0, 32'h1004, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'd12 || IRM !== I_ADDU || PC4M !== 32'h1004 || RTM !== 32'd7) begin
            failures++;
            $display("FAIL addu got aom=%h irm=%h pc4m=%h rtm=%h exp 0c %h 1004 7",
                     AOM, IRM, PC4M, RTM, I_ADDU);
        end
        WD_W = 32'd100;
        issue(I_ADDU, 32'd5, 32'd7, '0, 32'h1008, 2'd3, 2'd0);
        checks++;
        if (AOM !== 32'd107) begin
            failures++;
            $display("FAIL addu_fwd_wd got %h exp %h", AOM, 32'd107);
        end
        issue(I_SUBU, 32'd5, 32'd7, '0, 32'h100C, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL subu got %h exp fffffffe", AOM);
        end
        issue(I_SLT, 32'hFFFF_FFFF, 32'd1, '0, 32'h1010, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'd1) begin
            failures++;
            $display("FAIL slt_neg got %h exp 1", AOM);
        end
        issue(I_SLT, 32'd1, 32'hFFFF_FFFF, '0, 32'h1014, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'd0) begin
            failures++;
            $display("FAIL slt_pos got %h exp 0", AOM);
        end
        issue(I_ORI, 32'h0000_00F0, 32'hDEAD, 32'h0000_000F, 32'h1018, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'h0000_00FF || RTM !== 32'hDEAD) begin
            failures++;
            $display("FAIL ori got aom=%h rtm=%h exp 000000ff 0000dead", AOM, RTM);
        end
        issue(I_LUI, 32'h5, '0, 32'h1234_0000, 32'h101C, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'h1234_0000) begin
            failures++;
            $display("FAIL lui got %h exp 12340000", AOM);
        end
        issue(I_LW, 32'h100, '0, 32'h8, 32'h1020, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'h108) begin
            failures++;
            $display("FAIL lw got %h exp 00000108", AOM);
        end
        issue(I_JAL, '0, '0, '0, 32'h3004, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'h3008) begin
            failures++;
            $display("FAIL jal got %h exp 00003008", AOM);
        end
        // rs from AOM (0x3008) + 2
        issue(I_ADDU, 32'd999, 32'd2, '0, 32'h4000, 2'd1, 2'd0);
        checks++;
        if (AOM !== 32'h300A) begin
            failures++;
            $display("FAIL addu_fwd_aom got %h exp 0000300a", AOM);
        end
        // rt from PC4M+4 = 0x4004
        issue(I_ADDU, 32'd1, 32'd999, '0, 32'h4008, 2'd0, 2'd2);
        checks++;
        if (AOM !== 32'h4005 || RTM !== 32'h4004) begin
            failures++;
            $display("FAIL addu_fwd_pc got aom=%h rtm=%h exp 00004005 00004004", AOM, RTM);
        end
        issue('0, 32'd5, 32'd6, 32'd7, 32'h400C, 2'd0, 2'd0);
        checks++;
        if (AOM !== '0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL nop got aom=%h busy=%b exp 0 0", AOM, Busy);
        end
    endtask

    task automatic test_mult();
        int n;
        set_in(I_MULT, 32'hFFFF_FFFB, 32'd3, '0, 32'h5000, 2'd0, 2'd0);
        #1;
        checks++;
        if (Start !== 1'b1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL mult_start got start=%b busy=%b exp 1 0", Start, Busy);
        end
        tick();
        set_in('0, '0, '0, '0, '0, 2'd0, 2'd0);
        #1;
        checks++;
        if (Start !== 1'b0 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL mult_busy got start=%b busy=%b exp 0 1", Start, Busy);
        end
        wait_busy(n, 1'b0);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL mult_cycles got %0d exp 5", n);
        end
        issue(I_MFHI, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mult_hi got %h exp ffffffff", AOM);
        end
        issue(I_MFLO, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'hFFFF_FFF1) begin
            failures++;
            $display("FAIL mult_lo got %h exp fffffff1", AOM);
        end
        issue(I_MULTU, 32'hFFFF_FFFF, 32'd2, '0, '0, 2'd0, 2'd0);
        wait_busy(n, 1'b0);
        issue(I_MFHI, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'd1) begin
            failures++;
            $display("FAIL multu_hi got %h exp 00000001", AOM);
        end
        issue(I_MFLO, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL multu_lo got %h exp fffffffe", AOM);
        end
    endtask

    task automatic test_div();
        int n;
        issue(I_DIV, 32'hFFFF_FFF9, 32'd2, '0, '0, 2'd0, 2'd0);
        wait_busy(n, 1'b0);
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL div_cycles got %0d exp 10", n);
        end
        issue(I_MFLO, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_lo got %h exp fffffffd", AOM);
        end
        issue(I_MFHI, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_hi got %h exp ffffffff", AOM);
        end
        issue(I_MTHI, 32'h55, '0, '0, '0, 2'd0, 2'd0);
        issue(I_MTLO, 32'h55, '0, '0, '0, 2'd0, 2'd0);
        issue(I_DIVU, 32'd9, 32'd0, '0, '0, 2'd0, 2'd0);
        wait_busy(n, 1'b0);
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL divz_cycles got %0d exp 10", n);
        end
        issue(I_MFHI, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'h55) begin
            failures++;
            $display("FAIL divz_hi got %h exp 00000055", AOM);
        end
        issue(I_MFLO, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'h55) begin
            failures++;
            $display("FAIL divz_lo got %h exp 00000055", AOM);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        issue(I_MTHI, 32'h1234, '0, '0, '0, 2'd0, 2'd0);
        issue(I_DIV, 32'd100, 32'd7, '0, 32'h6000, 2'd0, 2'd0);
        set_in('0, '0, '0, '0, '0, 2'd0, 2'd0);
        tick(); tick(); tick();
        checks++;
        if (Busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy4 got %b exp 1", Busy);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (Busy !== 1'b0 || {IRM, PC4M, AOM, RTM} !== '0) begin
            failures++;
            $display("FAIL abort_clear got busy=%b %h %h %h %h exp 0", Busy, IRM, PC4M, AOM, RTM);
        end
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (Busy) n++;
            tick();
        end
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL abort_no_resume got %0d busy cycles exp 0", n);
        end
        issue(I_MFHI, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== '0) begin
            failures++;
            $display("FAIL abort_hi got %h exp 0", AOM);
        end
        issue(I_MFLO, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== '0) begin
            failures++;
            $display("FAIL abort_lo got %h exp 0", AOM);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(I_MULT, 32'd6, 32'd7, '0, '0, 2'd0, 2'd0);
        set_in(I_MULT, 32'd100, 32'd100, '0, '0, 2'd0, 2'd0);
        wait_busy(n, 1'b1);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL b2b_cycles got %0d exp 5", n);
        end
        issue(I_MFLO, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== 32'd42) begin
            failures++;
            $display("FAIL b2b_lo got %h exp 0000002a", AOM);
        end
        issue(I_MFHI, '0, '0, '0, '0, 2'd0, 2'd0);
        checks++;
        if (AOM !== '0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_hi got aom=%h busy=%b exp 0 0", AOM, Busy);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
